fifo_sync_flagged: RTL and testbench
====================================

// Module: fifo_sync_flagged
// PURPOSE
//   Parametrised single-clock FIFO; next generation of the team's sync FIFO.
//   Adds programmable almost-full/almost-empty thresholds, an occupancy count,
//   sticky overflow/underflow error flags and a first-word-fall-through (FWFT) mode.
//   Sits between producer/consumer stages in one clock domain; the data path is
//   identical in both read modes.
// PARAMETERS
//   DATA_WIDTH     8    word width in bits
//   ADDR_WIDTH     5    log2(depth); DEPTH = 2**ADDR_WIDTH (default 32)
//   FWFT           0    0 = standard registered read; 1 = first-word-fall-through
//   AFULL_THRESH   28   almost_full asserts when count >= AFULL_THRESH (1..DEPTH)
//   AEMPTY_THRESH  4    almost_empty asserts when count <= AEMPTY_THRESH (0..DEPTH-1)
// PORTS
//   clk           in   1             single clock, all logic on posedge
//   rst           in   1             asynchronous, active-high reset
//   wr_en         in   1             write request
//   data_in       in   DATA_WIDTH    write data, sampled with wr_en
//   rd_en         in   1             read request (FWFT: pop/acknowledge head word)
//   data_out      out  DATA_WIDTH    read data
//   full          out  1             count == DEPTH
//   empty         out  1             count == 0
//   almost_full   out  1             count >= AFULL_THRESH
//   almost_empty  out  1             count <= AEMPTY_THRESH
//   count         out  ADDR_WIDTH+1  current occupancy, 0..DEPTH
//   overflow      out  1             sticky: a write was rejected while full
//   underflow     out  1             sticky: a read was rejected while empty
//   clr_err       in   1             synchronous clear of overflow/underflow
// BEHAVIOUR
//   Reset (async assert, sync-release safe): wr_ptr=rd_ptr=0, count=0, empty=1, full=0,
//     almost_empty=1, almost_full=0, data_out=0, overflow=underflow=0. Memory not reset.
//   Acceptance: wr_acc = wr_en & ~full; rd_acc = rd_en & ~empty (flags as registered
//     at the current edge). No write-through-when-full: if full and rd_en & wr_en,
//     the read is accepted, the write is dropped and overflow sets.
//   Pointers: ADDR_WIDTH bits, natural wrap DEPTH-1 -> 0; advance by 1 on acceptance.
//   count' = count + wr_acc - rd_acc; both accepted -> count unchanged.
//   All flags are registered, computed from count', so they are valid the cycle
//     after the causing edge. No combinational path from inputs to any flag.
//   Standard mode (FWFT=0): on rd_acc, data_out <= mem[rd_ptr] at that edge
//     (latency 1). data_out holds its value when no read is accepted.
//   FWFT mode (FWFT=1): data_out = mem[rd_ptr] whenever empty=0 (head visible);
//     rd_en acknowledges/pops it and the next word appears after the same edge.
//     A write into an empty FIFO: empty deasserts and the word is on data_out
//     one cycle after the write edge. data_out is don't-care while empty=1.
//   Simultaneous read+write when empty: write accepted, read rejected, underflow sets;
//     the written word is not bypassed to the reader.
//   Errors: overflow <= overflow | (wr_en & full); underflow <= underflow | (rd_en & empty);
//     clr_err clears both; a new error in the same cycle as clr_err wins (flag stays 1).
//   Reset mid-operation: all state returns to reset values immediately; contents lost.
//   Elaboration checks ($error): AFULL_THRESH in 1..DEPTH, AEMPTY_THRESH < DEPTH,
//     FWFT in {0,1}.
// STRUCTURE
//   fifo_pkg (shared): function clog2-free DEPTH calc, typedef fifo_status_t
//     {full, empty, almost_full, almost_empty, overflow, underflow} for monitors.
//   One sub-module: fifo_dpram (register-array dual-port, 1 write port, async read
//     port, DATA_WIDTH x DEPTH). Top holds pointers, count, flags and the read-mode mux.
// TESTING  (DEPTH=32, DATA_WIDTH=8, thresholds 28/4; run for FWFT=0 and FWFT=1)
//   Reset: rst=1 for 3 cycles -> empty=1, full=0, count=0, almost_empty=1, errors=0.
//   Fill/drain: write 0x00..0x1F -> full=1 after 32nd write, almost_full at count=28;
//     read 32 -> data 0x00..0x1F in order, empty=1, almost_empty at count=4.
//   Wrap: 3 rounds of write-20/read-20 with data=index -> order preserved past ptr wrap,
//     count never exceeds 20.
//   Full+both: at count=32, wr_en=rd_en=1, data_in=0xAA -> count=31, overflow=1, 0xAA
//     never read; clr_err -> overflow=0 next cycle.
//   Empty+both: at count=0, wr_en=rd_en=1, data_in=0x55 -> underflow=1, count=1;
//     next read returns 0x55. FWFT: 0x55 on data_out one cycle after write.
//   Mid-op reset: 10 words in, pulse rst during a read -> count=0, empty=1 same cycle;
//     subsequent write 0x3C/read returns 0x3C.

Source files
------------

// File: rtl/fifo_pkg.sv
// ---------------------------------------------------------------------------
// fifo_pkg
//   Shared definitions for the flagged synchronous FIFO family.
//   - fifo_depth(): depth from address width without relying on $clog2.
//   - fifo_status_t: bundle of all status flags, used inside the FIFO to
//     hold the registered flags and available to monitors that want the
//     whole status word at once.
// ---------------------------------------------------------------------------
package fifo_pkg;

    // Number of storage words addressed by an addr_width-bit pointer.
    function automatic int fifo_depth(input int addr_width);
        return 1 << addr_width;
    endfunction

    typedef struct packed {
        logic full;
        logic empty;
        logic almost_full;
        logic almost_empty;
        logic overflow;
        logic underflow;
    } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// ---------------------------------------------------------------------------
// fifo_dpram
//   Register-array dual-port memory: one synchronous write port and one
//   asynchronous (combinational) read port. Contents are not reset.
// Ports
//   clk    in   write clock
//   we     in   write enable
//   waddr  in   write address, ADDR_WIDTH bits
//   wdata  in   write data, DATA_WIDTH bits
//   raddr  in   read address, ADDR_WIDTH bits
//   rdata  out  mem[raddr], DATA_WIDTH bits
// ---------------------------------------------------------------------------
module fifo_dpram
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic                  we,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [ADDR_WIDTH-1:0] raddr,
    output logic [DATA_WIDTH-1:0] rdata
);

    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_sync_flagged.sv
// ---------------------------------------------------------------------------
// fifo_sync_flagged
//   Single-clock FIFO with occupancy count, almost-full/almost-empty
//   thresholds, sticky overflow/underflow flags and an optional
//   first-word-fall-through read mode. All flags are registered and derived
//   from the next-state occupancy, so they are valid the cycle after the edge
//   that changed them.
// Ports
//   clk           in   single clock, posedge
//   rst           in   asynchronous active-high reset
//   wr_en         in   write request
//   data_in       in   write data, DATA_WIDTH bits
//   rd_en         in   read request (FWFT: pop the visible head word)
//   data_out      out  read data, DATA_WIDTH bits
//   full          out  count == DEPTH
//   empty         out  count == 0
//   almost_full   out  count >= AFULL_THRESH
//   almost_empty  out  count <= AEMPTY_THRESH
//   count         out  occupancy 0..DEPTH, ADDR_WIDTH+1 bits
//   overflow      out  sticky: write rejected while full
//   underflow     out  sticky: read rejected while empty
//   clr_err       in   synchronous clear of overflow/underflow
// ---------------------------------------------------------------------------
module fifo_sync_flagged
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDR_WIDTH    = 5,
    parameter int FWFT          = 0,
    parameter int AFULL_THRESH  = 28,
    parameter int AEMPTY_THRESH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_en,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  rd_en,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clr_err
);

    localparam int CNT_W = ADDR_WIDTH + 1;
    localparam int DEPTH = fifo_depth(ADDR_WIDTH);

    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_C  = CNT_W'(AFULL_THRESH);
    localparam logic [CNT_W-1:0] AEMPTY_C = CNT_W'(AEMPTY_THRESH);

    // Reject parameter combinations the flag logic cannot represent.
    if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
        $error("fifo_sync_flagged: AFULL_THRESH must be in 1..DEPTH");
    end
    if (AEMPTY_THRESH < 0 || AEMPTY_THRESH >= DEPTH) begin : g_bad_aempty
        $error("fifo_sync_flagged: AEMPTY_THRESH must be in 0..DEPTH-1");
    end
    if (FWFT != 0 && FWFT != 1) begin : g_bad_fwft
        $error("fifo_sync_flagged: FWFT must be 0 or 1");
    end

    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_next;
    fifo_status_t          status;
    fifo_status_t          status_next;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] ram_rdata;

    // Acceptance uses the registered flags, so a write while full is dropped
    // even if a read frees a slot at the same edge (no write-through).
    assign wr_acc = wr_en & ~status.full;
    assign rd_acc = rd_en & ~status.empty;

    // Next occupancy and the flag word derived from it. Error flags are
    // sticky; a new error in the same cycle as clr_err keeps the flag set.
    always_comb begin
        cnt_next                 = cnt + CNT_W'(wr_acc) - CNT_W'(rd_acc);
        status_next              = status;
        status_next.full         = (cnt_next == DEPTH_C);
        status_next.empty        = (cnt_next == '0);
        status_next.almost_full  = (cnt_next >= AFULL_C);
        status_next.almost_empty = (cnt_next <= AEMPTY_C);
        status_next.overflow     = (status.overflow  & ~clr_err) | (wr_en & status.full);
        status_next.underflow    = (status.underflow & ~clr_err) | (rd_en & status.empty);
    end

    // Pointers, occupancy and flags. Pointers wrap naturally at DEPTH.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            status <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                        almost_empty: 1'b1, overflow: 1'b0, underflow: 1'b0};
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            cnt    <= cnt_next;
            status <= status_next;
        end
    end

    fifo_dpram #(
        .DATA_WIDTH (DATA_WIDTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) u_ram (
        .clk   (clk),
        .we    (wr_acc),
        .waddr (wr_ptr),
        .wdata (data_in),
        .raddr (rd_ptr),
        .rdata (ram_rdata)
    );

    if (FWFT == 1) begin : g_fwft
        // Head word is visible as soon as the FIFO is non-empty; forced to
        // zero while empty so the output matches the reset value.
        assign data_out = status.empty ? '0 : ram_rdata;
    end else begin : g_std
        logic [DATA_WIDTH-1:0] data_q;

        // Registered read: the word under rd_ptr is captured on an accepted
        // read and held otherwise.
        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                data_q <= '0;
            end else if (rd_acc) begin
                data_q <= ram_rdata;
            end
        end

        assign data_out = data_q;
    end

    assign count        = cnt;
    assign full         = status.full;
    assign empty        = status.empty;
    assign almost_full  = status.almost_full;
    assign almost_empty = status.almost_empty;
    assign overflow     = status.overflow;
    assign underflow    = status.underflow;

endmodule

// File: tb/tb_fifo_sync_flagged.sv
// ---------------------------------------------------------------------------
// tb_fifo_sync_flagged
//   Drives one standard-mode and one FWFT-mode FIFO with identical stimulus.
//   A queue-based reference model predicts occupancy, flags and read data;
//   expected read words go into per-instance scoreboards that monitor
//   processes pop whenever each DUT presents a read word.
// ---------------------------------------------------------------------------
module tb_fifo_sync_flagged;

    localparam int DW = 8;
    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          wr_en;
    logic          rd_en;
    logic          clr_err;
    logic [DW-1:0] data_in;

    logic [DW-1:0] data_out_s, data_out_f;
    logic          full_s, empty_s, af_s, ae_s, ovf_s, unf_s;
    logic          full_f, empty_f, af_f, ae_f, ovf_f, unf_f;
    logic [AW:0]   count_s, count_f;

    int total = 0;
    int bad   = 0;

    // Reference model state
    int   mq[$];
    bit   ovf_m;
    bit   unf_m;

    // Scoreboards of expected read words
    int   sb_s[$];
    int   sb_f[$];
    bit   pend_s;

    always #5 clk = ~clk;

    fifo_sync_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(0),
                        .AFULL_THRESH(28), .AEMPTY_THRESH(4)) u_std (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out_s), .full(full_s), .empty(empty_s),
        .almost_full(af_s), .almost_empty(ae_s), .count(count_s),
        .overflow(ovf_s), .underflow(unf_s), .clr_err(clr_err)
    );

    fifo_sync_flagged #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FWFT(1),
                        .AFULL_THRESH(28), .AEMPTY_THRESH(4)) u_fwft (
        .clk(clk), .rst(rst), .wr_en(wr_en), .data_in(data_in), .rd_en(rd_en),
        .data_out(data_out_f), .full(full_f), .empty(empty_f),
        .almost_full(af_f), .almost_empty(ae_f), .count(count_f),
        .overflow(ovf_f), .underflow(unf_f), .clr_err(clr_err)
    );

    // Single comparison point: every check goes through here.
    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare count and flag word of both instances against the model.
    task automatic checkStatus(input string tag);
        int         n;
        logic [5:0] exp_flags;
        n = mq.size();
        exp_flags = {n == 32, n == 0, n >= 28, n <= 4, ovf_m, unf_m};
        checkOutput({tag, " std.count"}, 32'(count_s), 32'(n));
        checkOutput({tag, " std.flags"}, 32'({full_s, empty_s, af_s, ae_s, ovf_s, unf_s}), 32'(exp_flags));
        checkOutput({tag, " fwft.count"}, 32'(count_f), 32'(n));
        checkOutput({tag, " fwft.flags"}, 32'({full_f, empty_f, af_f, ae_f, ovf_f, unf_f}), 32'(exp_flags));
    endtask

    // One clock of stimulus. The model applies the acceptance rules to the
    // state before the edge and queues the word each DUT should deliver.
    task automatic applyStimulus(input bit we, input bit re, input bit clr, input logic [DW-1:0] din);
        bit full_m;
        bit empty_m;
        int head;
        wr_en   = we;
        rd_en   = re;
        clr_err = clr;
        data_in = din;
        full_m  = (mq.size() == 32);
        empty_m = (mq.size() == 0);
        ovf_m   = (ovf_m & ~clr) | (we & full_m);
        unf_m   = (unf_m & ~clr) | (re & empty_m);
        if (re && !empty_m) begin
            head = mq.pop_front();
            sb_s.push_back(head);
            sb_f.push_back(head);
        end
        if (we && !full_m) begin
            mq.push_back(int'(din));
        end
        @(posedge clk);
        #1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        checkStatus("step");
    endtask

    // Standard mode: the word appears the cycle after an accepted read.
    always @(negedge clk) begin
        int exp;
        if (rst) begin
            pend_s = 1'b0;
        end else begin
            if (pend_s) begin
                if (sb_s.size() == 0) begin
                    checkOutput("std.unexpected_read", 32'(data_out_s), 32'hFFFF_FFFF);
                end else begin
                    exp = sb_s.pop_front();
                    checkOutput("std.data_out", 32'(data_out_s), 32'(exp));
                end
            end
            pend_s = rd_en && !empty_s;
        end
    end

    // FWFT mode: the head word is on data_out while it is being popped.
    always @(negedge clk) begin
        int exp;
        if (!rst && rd_en && !empty_f) begin
            if (sb_f.size() == 0) begin
                checkOutput("fwft.unexpected_read", 32'(data_out_f), 32'hFFFF_FFFF);
            end else begin
                exp = sb_f.pop_front();
                checkOutput("fwft.data_out", 32'(data_out_f), 32'(exp));
            end
        end
    end

    initial begin
        rst     = 1'b1;
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
        data_in = '0;
        ovf_m   = 1'b0;
        unf_m   = 1'b0;
        pend_s  = 1'b0;

        // Reset held for three cycles
        repeat (3) @(posedge clk);
        #1;
        checkStatus("reset");
        checkOutput("reset std.data_out", 32'(data_out_s), 32'h0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Fill 0x00..0x1F then drain in order
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(i));
        for (int i = 0; i < 32; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Pointer wrap: three rounds of write-20 / read-20
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 20; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(r * 20 + i));
            for (int i = 0; i < 20; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        end
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Full with simultaneous read+write: read taken, 0xAA dropped
        for (int i = 0; i < 32; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'h40 + i));
        applyStimulus(1'b1, 1'b1, 1'b0, 8'hAA);
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        for (int i = 0; i < 31; i++) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Empty with simultaneous read+write: write taken, read rejected
        applyStimulus(1'b1, 1'b1, 1'b0, 8'h55);
        checkOutput("empty_both fwft.head", 32'(data_out_f), 32'h55);
        applyStimulus(1'b0, 1'b1, 1'b1, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Randomised traffic: write-biased half, then read-biased half
        for (int i = 0; i < 400; i++) begin
            int wbias;
            wbias = (i < 200) ? 70 : 30;
            applyStimulus($urandom_range(0, 99) < wbias,
                          $urandom_range(0, 99) < (100 - wbias),
                          $urandom_range(0, 99) < 5,
                          8'($urandom));
        end
        applyStimulus(1'b0, 1'b0, 1'b1, 8'h00);
        while (mq.size() > 0) applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Reset in the middle of a read with ten words stored
        for (int i = 0; i < 10; i++) applyStimulus(1'b1, 1'b0, 1'b0, 8'(8'hC0 + i));
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        rd_en = 1'b1;
        rst   = 1'b1;
        mq.delete();
        ovf_m = 1'b0;
        unf_m = 1'b0;
        #1;
        checkOutput("midreset std.count", 32'(count_s), 32'h0);
        checkOutput("midreset std.empty", 32'(empty_s), 32'h1);
        checkOutput("midreset fwft.count", 32'(count_f), 32'h0);
        checkOutput("midreset fwft.empty", 32'(empty_f), 32'h1);
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rd_en = 1'b0;
        checkStatus("after_reset");
        applyStimulus(1'b1, 1'b0, 1'b0, 8'h3C);
        applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
        applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);

        // Every predicted read word must have been delivered
        checkOutput("std.leftover", 32'(sb_s.size()), 32'h0);
        checkOutput("fwft.leftover", 32'(sb_f.size()), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
